// File: rtl/comparator_serial128.sv
// Chunk-serial 128-bit signed/unsigned magnitude comparator, MSB slice first.
// Optional feature: define EARLY_EXIT_EN to end the scan on the first differing slice.
module comparator_serial128 #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             eq_o,
  output logic             lt_o,
  output logic             ltu_o
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(N - 1);

`ifdef EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             found_q, found_d;
  logic             accLt_q, accLt_d;
  logic             accLtu_q, accLtu_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             ltu_q, ltu_d;

  logic [CHUNK-1:0] slices1 [N];
  logic [CHUNK-1:0] slices2 [N];
  logic [CHUNK-1:0] sliceA, sliceB;
  logic             sliceDiff, sliceLt, sliceLtu, firstDiff, scanLast;

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign slices1[g] = op1_q[g*CHUNK +: CHUNK];
    assign slices2[g] = op2_q[g*CHUNK +: CHUNK];
  end

  assign sliceA = slices1[idx_q];
  assign sliceB = slices2[idx_q];

  // Only the top slice carries the sign; every lower slice orders as unsigned.
  always_comb begin
    sliceDiff = (sliceA != sliceB);
    sliceLtu  = (sliceA < sliceB);
    if (idx_q == TOP_IDX) begin
      sliceLt = ($signed(sliceA) < $signed(sliceB));
    end else begin
      sliceLt = sliceLtu;
    end
  end

  assign firstDiff = sliceDiff && !found_q;
  assign scanLast  = (idx_q == '0) || (EARLY_EXIT && sliceDiff);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    found_d  = found_q;
    accLt_d  = accLt_q;
    accLtu_d = accLtu_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          op1_d    = op1_i;
          op2_d    = op2_i;
          idx_d    = TOP_IDX;
          found_d  = 1'b0;
          accLt_d  = 1'b0;
          accLtu_d = 1'b0;
          state_d  = SCAN;
        end
      end

      SCAN: begin
        found_d = found_q | sliceDiff;
        if (firstDiff) begin
          accLt_d  = sliceLt;
          accLtu_d = sliceLtu;
        end
        // Published results only change here, so they hold across the next scan.
        if (scanLast) begin
          eq_d    = !found_d;
          lt_d    = accLt_d;
          ltu_d   = accLtu_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      found_q  <= 1'b0;
      accLt_q  <= 1'b0;
      accLtu_q <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      found_q  <= found_d;
      accLt_q  <= accLt_d;
      accLtu_q <= accLtu_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign eq_o   = eq_q;
  assign lt_o   = lt_q;
  assign ltu_o  = ltu_q;

endmodule

// File: tb/tb_comparator_serial128.sv
// Scoreboard bench for comparator_serial128; expected results come from full-width compares.
// Latency expectations follow EARLY_EXIT_EN when it is defined for the build.
module tb_comparator_serial128;

  localparam int WIDTH = 128;
  localparam int CHUNK = 32;
  localparam int N     = WIDTH / CHUNK;

  typedef struct {
    logic eq;
    logic lt;
    logic ltu;
    int   lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start_i;
  logic [WIDTH-1:0] op1_i, op2_i;
  logic             busy_o, done_o, eq_o, lt_o, ltu_o;

  int   vectors     = 0;
  int   miscompares = 0;
  int   doneCount   = 0;
  int   reqCount    = 0;
  exp_t sbQ[$];
  exp_t lastExp;

  always #5 clk = ~clk;

  comparator_serial128 #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (start_i),
    .op1_i   (op1_i),
    .op2_i   (op2_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .eq_o    (eq_o),
    .lt_o    (lt_o),
    .ltu_o   (ltu_o)
  );

  always @(negedge clk) begin
    if (done_o === 1'b1) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    e.eq  = (a == b);
    e.ltu = (a < b);
    e.lt  = ($signed(a) < $signed(b));
    e.lat = N;
`ifdef EARLY_EXIT_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) begin
        e.lat = N - i;
        break;
      end
    end
`endif
    return e;
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit holdStart);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_o === 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    op1_i   = a;
    op2_i   = b;
    start_i = 1'b1;
    sbQ.push_back(model(a, b));
    @(posedge clk);
    #1;
    op1_i = ~a;
    op2_i = a ^ b;
    if (!holdStart) start_i = 1'b0;
  endtask

  task automatic waitDone(input string tag, input bit holdStart);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) checkOutput({tag, "_busy_scan"}, 32'(busy_o), 32'd1);
      if (done_o === 1'b1) begin
        seen = 1'b1;
      end else if (holdStart) begin
        op1_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        op2_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    start_i = 1'b0;
    if (!seen) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      if (sbQ.size() > 0) void'(sbQ.pop_front());
      return;
    end
    if (sbQ.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sbQ.pop_front();
    reqCount++;
    lastExp = e;
    checkOutput({tag, "_eq"},   32'(eq_o),   32'(e.eq));
    checkOutput({tag, "_lt"},   32'(lt_o),   32'(e.lt));
    checkOutput({tag, "_ltu"},  32'(ltu_o),  32'(e.ltu));
    checkOutput({tag, "_lat"},  32'(cyc),    32'(e.lat));
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  task automatic runOne(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    applyStimulus(a, b, 1'b0);
    waitDone(tag, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    bit               anyDone;
    int               s;

    reset_n = 1'b0;
    start_i = 1'b0;
    op1_i   = '0;
    op2_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_eq",   32'(eq_o),   32'd0);
    checkOutput("rst_lt",   32'(lt_o),   32'd0);
    checkOutput("rst_ltu",  32'(ltu_o),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    runOne("equal", {WIDTH/4{4'hA}}, {WIDTH/4{4'hA}});
    runOne("top_signed", {32'h8000_0000, 96'h0}, 128'h1);
    runOne("bottom", 128'h1, 128'h2);
    runOne("mixed", {32'h0000_0001, 96'h0}, {WIDTH{1'b1}});
    runOne("swapped", {WIDTH{1'b1}}, {32'h0000_0001, 96'h0});

    for (int i = 0; i < 6; i++) begin
      a = {$urandom(), $urandom(), $urandom(), $urandom()};
      b = a;
      s = $urandom_range(0, N - 1);
      b[s*CHUNK +: CHUNK] = $urandom();
      runOne("random", a, b);
    end

    applyStimulus({32'h7FFF_FFFF, 32'h0, 64'h5}, {32'h7FFF_FFFF, 32'h0, 64'h9}, 1'b1);
    waitDone("held_start", 1'b1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("held_idle_busy", 32'(busy_o), 32'd0);
    checkOutput("held_done_count", 32'(doneCount), 32'(reqCount));

    anyDone = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done_o !== 1'b0) anyDone = 1'b1;
    end
    checkOutput("hold_done", 32'(anyDone), 32'd0);
    checkOutput("hold_eq",   32'(eq_o),    32'(lastExp.eq));
    checkOutput("hold_lt",   32'(lt_o),    32'(lastExp.lt));
    checkOutput("hold_ltu",  32'(ltu_o),   32'(lastExp.ltu));

    runOne("pre_reset_equal", 128'h1234, 128'h1234);
    applyStimulus(128'h1, 128'h2, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    checkOutput("midrst_done", 32'(done_o), 32'd0);
    checkOutput("midrst_eq",   32'(eq_o),   32'd0);
    checkOutput("midrst_lt",   32'(lt_o),   32'd0);
    checkOutput("midrst_ltu",  32'(ltu_o),  32'd0);
    if (sbQ.size() > 0) void'(sbQ.pop_back());
    @(negedge clk);
    reset_n = 1'b1;
    runOne("post_reset", {WIDTH{1'b1}}, 128'h5);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_done_count", 32'(doneCount), 32'(reqCount));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
